// File: rtl/mbinit_cal_responder.sv
// rtl/mbinit_cal_responder.sv - partner-side MBINIT.CAL done request/response handshake
module mbinit_cal_responder #(
   parameter int SB_MSG_WIDTH   = 4,
   parameter int TIMEOUT_CYCLES = 800000
) (
   input  logic                    CLK,
   input  logic                    rst_n,
   input  logic                    i_MBINIT_PARAM_end,
   input  logic                    i_falling_edge_busy,
   input  logic                    i_Busy_SideBand,
   input  logic [SB_MSG_WIDTH-1:0] i_RX_SbMessage,
   input  logic                    i_msg_valid,
   output logic [SB_MSG_WIDTH-1:0] o_TX_SbMessage,
   output logic                    o_ValidOutDatat_Module,
   output logic                    o_MBINIT_CAL_resp_end,
   output logic                    o_timeout_error
);

   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [SB_MSG_WIDTH-1:0] MSG_DONE_REQ  = SB_MSG_WIDTH'(1);
   localparam logic [SB_MSG_WIDTH-1:0] MSG_DONE_RESP = SB_MSG_WIDTH'(2);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WAIT_REQ  = 3'd1,
      ST_SEND_RESP = 3'd2,
      ST_DONE      = 3'd3,
      ST_ERROR     = 3'd4
   } state_t;

   state_t         state;
   state_t         state_nxt;
   logic [TW-1:0]  timer;
   logic           req_pending;

   logic enable;
   logic req_hit;
   logic serve;
   logic expired;

   assign enable  = i_MBINIT_PARAM_end;
   assign req_hit = i_msg_valid && (i_RX_SbMessage == MSG_DONE_REQ);
   assign serve   = (req_hit || req_pending) && !i_Busy_SideBand;
   assign expired = (timer == TIMER_LAST);

   // Next-state selection: enable low first, then completion/serve, then timeout.
   always_comb begin
      state_nxt = ST_IDLE;
      if (!enable) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:      state_nxt = ST_WAIT_REQ;
            ST_WAIT_REQ: begin
               if (serve)        state_nxt = ST_SEND_RESP;
               else if (expired) state_nxt = ST_ERROR;
               else              state_nxt = ST_WAIT_REQ;
            end
            ST_SEND_RESP: begin
               if (i_falling_edge_busy) state_nxt = ST_DONE;
               else if (expired)        state_nxt = ST_ERROR;
               else                     state_nxt = ST_SEND_RESP;
            end
            ST_DONE: begin
               if (serve) state_nxt = ST_SEND_RESP;
               else       state_nxt = ST_DONE;
            end
            ST_ERROR:     state_nxt = ST_ERROR;
            default:      state_nxt = ST_IDLE;
         endcase
      end
   end

   // State, timeout timer, request latch and outputs decoded from the next state.
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         state                  <= ST_IDLE;
         timer                  <= '0;
         req_pending            <= 1'b0;
         o_TX_SbMessage         <= '0;
         o_ValidOutDatat_Module <= 1'b0;
         o_MBINIT_CAL_resp_end  <= 1'b0;
         o_timeout_error        <= 1'b0;
      end else begin
         state <= state_nxt;

         // Saturates at the last count so a late serve cannot wrap the budget.
         if (state == ST_WAIT_REQ || state == ST_SEND_RESP) begin
            if (!expired) timer <= timer + TW'(1);
         end else begin
            timer <= '0;
         end

         if (!enable || (state_nxt == ST_SEND_RESP && state != ST_SEND_RESP))
            req_pending <= 1'b0;
         else if (req_hit && state != ST_ERROR)
            req_pending <= 1'b1;

         o_TX_SbMessage         <= '0;
         o_ValidOutDatat_Module <= 1'b0;
         o_MBINIT_CAL_resp_end  <= 1'b0;
         o_timeout_error        <= 1'b0;
         case (state_nxt)
            ST_SEND_RESP: begin
               o_ValidOutDatat_Module <= 1'b1;
               o_TX_SbMessage         <= MSG_DONE_RESP;
            end
            ST_DONE:  o_MBINIT_CAL_resp_end <= 1'b1;
            ST_ERROR: o_timeout_error       <= 1'b1;
            default: ;
         endcase
      end
   end

endmodule
